// File: rtl/time_set_controller.sv
// Time-setting sequencer: turns debounced mode/inc buttons into minute and hour
// offsets, drives digit-blink enables and falls back to RUN after inactivity.
module time_set_controller #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] h,
  output logic [6:0] i,
  output logic [1:0] mode,
  output logic       blink_min,
  output logic       blink_hr
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] SET_MIN  = 2'b01;
  localparam logic [1:0] SET_HOUR = 2'b10;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    h_d;
  logic [6:0]    i_d;
  logic          btn_mode_q, btn_inc_q;
  // Low for the first cycle after reset so a button held through reset is not a press.
  logic          live_q;
  // Set by a fresh inc press, cleared on release: only a genuine hold may auto-repeat.
  logic          armed_q, armed_d;
  logic          repeating_q, repeating_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          phase_q, phase_d;
  logic          blink_min_d, blink_hr_d;

  logic in_set, mode_press, inc_press, hold_hit, strobe, inc_event, timeout, state_chg;

  assign in_set     = (state_q != RUN);
  assign mode_press = live_q & btn_mode & ~btn_mode_q;
  assign inc_press  = live_q & btn_inc & ~btn_inc_q;
  assign hold_hit   = repeating_q ? (hold_cnt_q == REP_LAST) : (hold_cnt_q == HOLD_LAST);
  assign strobe     = in_set & btn_inc & armed_q & hold_hit;
  assign inc_event  = in_set & (inc_press | strobe);
  // An increment on the final tick counts as activity and cancels the timeout.
  assign timeout    = in_set & tick_1hz & (idle_cnt_q == IDLE_LAST) & ~inc_event;
  assign state_chg  = (state_d != state_q);
  assign mode       = state_q;

  // Next-state: FSM, offsets, repeat/idle counters and blink phase.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = RUN;
    end else if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_HOUR;
        default: state_d = RUN;
      endcase
    end

    // A mode press in the same cycle wins over the increment.
    h_d = h;
    i_d = i;
    if (inc_event && !mode_press) begin
      if (state_q == SET_MIN) h_d = (h == 8'd59) ? 8'd0 : h + 8'd1;
      if (state_q == SET_HOUR) i_d = (i == 7'd23) ? 7'd0 : i + 7'd1;
    end

    armed_d = armed_q;
    if (!btn_inc) armed_d = 1'b0;
    else if (inc_press) armed_d = 1'b1;

    hold_cnt_d  = hold_cnt_q + 1'b1;
    repeating_d = repeating_q;
    if (state_chg || inc_press || !btn_inc || !in_set || !armed_q) begin
      hold_cnt_d  = '0;
      repeating_d = 1'b0;
    end else if (strobe) begin
      hold_cnt_d  = '0;
      repeating_d = 1'b1;
    end

    idle_cnt_d = idle_cnt_q;
    if (mode_press || inc_event || state_d == RUN) idle_cnt_d = '0;
    else if (tick_1hz && in_set) idle_cnt_d = idle_cnt_q + 1'b1;

    phase_d = phase_q;
    if (state_chg) phase_d = 1'b0;
    else if (tick_1hz && in_set) phase_d = ~phase_q;

    blink_min_d = (state_d == SET_MIN) & phase_d;
    blink_hr_d  = (state_d == SET_HOUR) & phase_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      h           <= '0;
      i           <= '0;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      live_q      <= 1'b0;
      armed_q     <= 1'b0;
      repeating_q <= 1'b0;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      phase_q     <= 1'b0;
      blink_min   <= 1'b0;
      blink_hr    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h           <= h_d;
      i           <= i_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      live_q      <= 1'b1;
      armed_q     <= armed_d;
      repeating_q <= repeating_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      phase_q     <= phase_d;
      blink_min   <= blink_min_d;
      blink_hr    <= blink_hr_d;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed test-plan sequences plus random
// stimulus, checked against a behavioural model through a scoreboard queue.
module tb_time_set_controller;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TO   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] h;
  logic [6:0] i;
  logic [1:0] mode;
  logic       blink_min;
  logic       blink_hr;

  time_set_controller #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .TIMEOUT_S    (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .h        (h),
    .i        (i),
    .mode     (mode),
    .blink_min(blink_min),
    .blink_hr (blink_hr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] h;
    logic [6:0] i;
    logic       bmin;
    logic       bhr;
  } out_t;

  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state: offsets as plain integers, repeat timing by cycle arithmetic.
  int m_st = 0, m_h = 0, m_i = 0, m_idle = 0, m_cyc = 0, m_anchor = 0;
  bit m_phase = 0, m_armed = 0, m_started = 0, m_pm = 0, m_pi = 0;

  task automatic step(input bit rn, input bit tk, input bit bm, input bit bi);
    out_t e;
    int   d, nst;
    bit   mp, ip, set, strobe, ev, tmo;
    @(negedge clk);
    rst_n = rn; tick_1hz = tk; btn_mode = bm; btn_inc = bi;
    if (!rn) begin
      m_st = 0; m_h = 0; m_i = 0; m_idle = 0; m_phase = 0;
      m_armed = 0; m_started = 0; m_pm = 0; m_pi = 0;
    end else begin
      mp     = m_started && bm && !m_pm;
      ip     = m_started && bi && !m_pi;
      set    = (m_st != 0);
      d      = m_cyc - m_anchor;
      strobe = set && bi && m_armed && !ip &&
               (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0));
      ev     = set && (ip || strobe);
      tmo    = set && tk && (m_idle == TO - 1) && !ev;
      nst    = tmo ? 0 : (mp ? (m_st + 1) % 3 : m_st);
      if (ev && !mp) begin
        if (m_st == 1) m_h = (m_h + 1) % 60;
        else m_i = (m_i + 1) % 24;
      end
      if (mp || ev || nst == 0) m_idle = 0;
      else if (tk && set) m_idle++;
      if (nst != m_st) m_phase = 0;
      else if (tk && set) m_phase = !m_phase;
      if (ip || nst != m_st) m_anchor = m_cyc;
      if (!bi) m_armed = 0;
      else if (ip) m_armed = 1;
      m_st = nst; m_pm = bm; m_pi = bi; m_started = 1;
    end
    m_cyc++;
    e.mode = 2'(m_st);
    e.h    = 8'(m_h);
    e.i    = 7'(m_i);
    e.bmin = (m_st == 1) && m_phase;
    e.bhr  = (m_st == 2) && m_phase;
    exp_q.push_back(e);
  endtask

  // Monitor: one registered output set per clock, compared against the queued expectation.
  always @(posedge clk) begin
    out_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{mode, h, i, blink_min, blink_hr};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got mode=%0d h=%0d i=%0d bmin=%0b bhr=%0b exp mode=%0d h=%0d i=%0d bmin=%0b bhr=%0b",
                 $time, a.mode, a.h, a.i, a.bmin, a.bhr, e.mode, e.h, e.i, e.bmin, e.bhr);
      end
    end
  end

  // Directed check against hand-derived constants, sampled after the pending edge.
  task automatic chk(input string name, input int em, input int eh, input int ei,
                     input bit ebm, input bit ebh);
    @(posedge clk);
    #2;
    tests++;
    if (mode !== 2'(em) || h !== 8'(eh) || i !== 7'(ei) || blink_min !== ebm || blink_hr !== ebh) begin
      fails++;
      $display("FAIL %s got mode=%0d h=%0d i=%0d bmin=%0b bhr=%0b exp mode=%0d h=%0d i=%0d bmin=%0b bhr=%0b",
               name, mode, h, i, blink_min, blink_hr, em, eh, ei, ebm, ebh);
    end
  endtask

  task automatic mpress();
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic ipress();
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
  endtask

  initial begin
    bit bm_l = 0, bi_l = 0, tk, rn;
    int guard;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    step(1, 0, 1, 0); chk("mode_1", 1, 0, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0); chk("mode_2", 2, 0, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0); chk("mode_3", 0, 0, 0, 0, 0); step(1, 0, 0, 0);

    mpress();
    for (int n = 0; n < 61; n++) ipress();
    chk("h_wrap", 1, 1, 0, 0, 0);
    mpress();
    for (int n = 0; n < 25; n++) ipress();
    chk("i_wrap", 2, 1, 1, 0, 0);

    mpress(); mpress();
    for (int n = 0; n < 20; n++) step(1, 0, 0, 1);
    chk("auto_repeat", 1, 5, 1, 0, 0);
    step(1, 0, 0, 0);
    mpress(); mpress();
    for (int n = 0; n < 20; n++) step(1, 0, 0, 1);
    chk("run_ignore", 0, 5, 1, 0, 0);
    step(1, 0, 0, 0);

    mpress(); mpress();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("timeout", 0, 5, 1, 0, 0);

    mpress(); mpress();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 1); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("no_timeout", 2, 5, 2, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("late_timeout", 0, 5, 2, 0, 0);

    mpress();
    step(1, 1, 0, 0); chk("blink_1", 1, 5, 2, 1, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); chk("blink_2", 1, 5, 2, 0, 0); step(1, 0, 0, 0);
    ipress();
    step(1, 1, 0, 0); chk("blink_3", 1, 6, 2, 1, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); chk("blink_4", 1, 6, 2, 0, 0); step(1, 0, 0, 0);
    ipress();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0); chk("blink_clear", 2, 7, 2, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); chk("blink_hr", 2, 7, 2, 0, 1); step(1, 0, 0, 0);

    mpress(); mpress();
    step(1, 0, 1, 1);
    chk("mode_beats_inc", 2, 7, 2, 0, 0);
    step(1, 0, 0, 0);

    mpress(); mpress();
    for (int n = 0; n < 22; n++) ipress();
    for (int n = 0; n < 5; n++) step(1, 0, 0, 1);
    chk("h_30", 1, 30, 2, 0, 0);
    step(0, 0, 0, 1);
    chk("reset_mid_hold", 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) step(1, 0, 0, 1);
    chk("no_repeat_after_reset", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) < 8) bm_l = !bm_l;
      if ($urandom_range(99) < 9) bi_l = !bi_l;
      tk = ($urandom_range(7) == 0);
      rn = ($urandom_range(399) != 0);
      step(rn, tk, bm_l, bi_l);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
